// File: rtl/risc16_mem_arbiter.sv
// Arbitrates the single-port RiSC16 word memory between instruction fetch (I)
// and load/store (D). It also holds a clear engine that zeroes one word per cycle.
// Memory writes commit on the negedge of clk. A read grant therefore sees data
// written by the previous grant.
module risc16_mem_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_SIZE    = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  // fetch port (read-only)
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   i_gnt,
  output logic                   i_rvalid,
  output logic [WORD_LENGTH-1:0] i_rdata,
  // load/store port
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  // clear engine
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  // memory side
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [WORD_LENGTH-1:0] mem_dataIn,
  output logic                   mem_writeEn,
  input  logic [WORD_LENGTH-1:0] mem_dataOut
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // The last word index is compared before incrementing. This keeps the
  // counter from wrapping even when MEM_SIZE == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                 state_q, state_d;
  logic                   last_d_q, last_d_d;   // 1: last grant went to D
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   clr_done_q, clr_done_d;
  logic                   i_rvalid_q, d_rvalid_q;
  logic [WORD_LENGTH-1:0] i_rdata_q, d_rdata_q;

  // Arbitration, clear sequencing and memory-side drive.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    clr_done_d  = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    mem_address = i_addr;
    mem_dataIn  = d_wdata;
    mem_writeEn = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Round-robin: the port that lost last time wins now.
          i_gnt = last_d_q;
          d_gnt = !last_d_q;
        end else begin
          i_gnt = i_req;
          d_gnt = d_req;
        end

        if (i_gnt) begin
          mem_address = i_addr;
          last_d_d    = 1'b0;
        end else if (d_gnt) begin
          mem_address = d_addr;
          mem_writeEn = d_we;
          last_d_d    = 1'b1;
        end

        // The cycle that samples clr_start still arbitrates normally.
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end

      CLEAR: begin
        mem_address = cnt_q;
        mem_dataIn  = '0;
        mem_writeEn = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and read-response registers. Reset squashes pending responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_gnt && !d_we;
      if (i_gnt) begin
        i_rdata_q <= mem_dataOut;
      end
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_dataOut;
      end
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench for risc16_mem_arbiter. It includes a 256-word behavioural
// memory that writes on negedge and reads combinationally. MEM_SIZE is 16, so
// the clear covers words 0..15.
module tb_risc16_mem_arbiter;

  localparam int WL = 16;
  localparam int AW = 16;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [WL-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [WL-1:0] d_wdata, d_rdata;
  logic          clr_start, clr_busy, clr_done;
  logic [AW-1:0] mem_address;
  logic [WL-1:0] mem_dataIn, mem_dataOut;
  logic          mem_writeEn;

  int vectors = 0;
  int errors  = 0;

  // behavioural memory plus a bulk-fill hook for preloading
  logic [WL-1:0] mem [0:255];
  logic          fill = 1'b0;

  function automatic logic [WL-1:0] pat(input int a);
    return (a == 16) ? 16'hA5A5 : 16'(16'h1000 + a);
  endfunction

  always @(negedge clk) begin
    if (fill) begin
      for (int k = 0; k < 256; k++) mem[k] <= pat(k);
    end else if (mem_writeEn) begin
      mem[mem_address[7:0]] <= mem_dataIn;
    end
  end

  assign mem_dataOut = mem[mem_address[7:0]];

  always #5 clk = ~clk;

  risc16_mem_arbiter #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_writeEn(mem_writeEn),
    .mem_dataOut(mem_dataOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill();
    fill = 1'b1;
    @(negedge clk);
    #1 fill = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    clr_start = 0;
    tick(); tick();
    // reset state
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    rst = 1'b0;
    do_fill();
    tick();

    // single fetch
    i_req = 1; i_addr = 16'h0010; #1;
    check("fetch_i_gnt", i_gnt, 1);
    check("fetch_d_gnt", d_gnt, 0);
    check("fetch_addr", mem_address, 16'h0010);
    check("fetch_we", mem_writeEn, 0);
    tick(); i_req = 0;
    check("fetch_i_rvalid", i_rvalid, 1);
    check("fetch_i_rdata", i_rdata, 16'hA5A5);
    tick();
    check("fetch_rvalid_1cyc", i_rvalid, 0);
    $display("txn fetch 0x0010 -> %h", 16'hA5A5);

    // write then read same address
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234; #1;
    check("wr_d_gnt", d_gnt, 1);
    check("wr_we", mem_writeEn, 1);
    check("wr_addr", mem_address, 16'h0020);
    check("wr_data", mem_dataIn, 16'h1234);
    tick(); d_we = 0; #1;
    check("rd_d_gnt", d_gnt, 1);
    check("rd_we", mem_writeEn, 0);
    check("wr_no_rvalid", d_rvalid, 0);
    check("wr_rdata_kept", d_rdata, 0);
    tick(); d_req = 0;
    check("rd_d_rvalid", d_rvalid, 1);
    check("rd_d_rdata", d_rdata, 16'h1234);
    tick();
    $display("txn D write 0x0020 <- 1234, read back %h", 16'h1234);

    // contention right after reset: I, D, I, D
    rst = 1; tick(); rst = 0;
    i_req = 1; i_addr = 16'h0030; d_req = 1; d_we = 0; d_addr = 16'h0031; #1;
    check("cont1_i_gnt", i_gnt, 1);
    check("cont1_d_gnt", d_gnt, 0);
    tick();
    check("cont2_d_gnt", d_gnt, 1);
    check("cont2_i_gnt", i_gnt, 0);
    check("cont2_i_rvalid", i_rvalid, 1);
    check("cont2_i_rdata", i_rdata, 16'h1030);
    tick();
    check("cont3_i_gnt", i_gnt, 1);
    check("cont3_d_rvalid", d_rvalid, 1);
    check("cont3_d_rdata", d_rdata, 16'h1031);
    check("cont3_i_rvalid", i_rvalid, 0);
    tick();
    check("cont4_d_gnt", d_gnt, 1);
    check("cont4_i_rvalid", i_rvalid, 1);
    tick(); i_req = 0; d_req = 0;
    check("cont5_d_rvalid", d_rvalid, 1);
    tick();
    $display("txn contention I,D,I,D done");

    // clear with a re-pulse of clr_start on cycle 5 and a fetch held throughout
    clr_start = 1; tick(); clr_start = 0;
    i_req = 1; i_addr = 16'h0010;
    for (int k = 0; k < MS; k++) begin
      if (k == 5) clr_start = 1;
      #1;
      check("clr_busy", clr_busy, 1);
      check("clr_done_early", clr_done, 0);
      check("clr_i_stall", i_gnt, 0);
      check("clr_addr", mem_address, k);
      check("clr_we", mem_writeEn, 1);
      tick();
      clr_start = 0;
    end
    check("clr_end_busy", clr_busy, 0);
    check("clr_end_done", clr_done, 1);
    check("clr_end_i_gnt", i_gnt, 1);
    tick(); i_req = 0;
    check("clr_done_pulse", clr_done, 0);
    check("clr_post_fetch", i_rdata, 16'hA5A5);
    for (int k = 0; k < MS; k++) check("clr_word_zero", mem[k], 0);
    check("clr_word_outside", mem[16], 16'hA5A5);
    $display("txn clear 16 words done");

    // reset in the 8th clear cycle (word 7 written), no clr_done
    do_fill();
    clr_start = 1; tick(); clr_start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) rst = 1;
      #1;
      check("abort_busy", clr_busy, 1);
      tick();
    end
    check("abort_busy_off", clr_busy, 0);
    check("abort_no_done", clr_done, 0);
    rst = 0;
    tick();
    check("abort_no_done2", clr_done, 0);
    for (int k = 0; k < MS; k++)
      check("abort_word", mem[k], (k < 8) ? 16'h0000 : pat(k));
    $display("txn clear aborted by reset at word 7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
